// File: rtl/ipg_slot_sched.sv
// Per-cycle transmit slot scheduler: picks network, request, memory-reply or idle
// for each 66b block, inserting IPG messages into inter-frame gaps.
module ipg_slot_sched #(
    parameter int unsigned MIN_IDLE = 1,
    parameter int unsigned GAP_W    = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ipg_en,
    input  logic             netq_empty,
    input  logic [1:0]       netq_outc,
    input  logic [7:0]       netq_bt,
    input  logic             reqq_empty,
    input  logic             memq_empty,
    output logic             netq_read,
    output logic             reqq_read,
    output logic             memq_read,
    output logic [1:0]       sel,
    output logic [1:0]       tuser,
    output logic             underrun_err,
    output logic [CNT_W-1:0] ins_cnt
);

    typedef enum logic {
        ST_GAP,
        ST_FRAME
    } state_t;

    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(MIN_IDLE);
    localparam logic [GAP_W-1:0] GAP_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state, state_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic             rr_mem;
    logic             insert, ins_mem;
    logic             head_ctrl, head_start, head_term, head_idle;

    assign head_ctrl = !netq_empty && (netq_outc == 2'b01);

    always_comb begin
        head_start = 1'b0;
        head_term  = 1'b0;
        head_idle  = 1'b0;
        if (head_ctrl) begin
            case (netq_bt)
                8'h78, 8'h33, 8'h66: head_start = 1'b1;
                8'h87, 8'h99, 8'haa, 8'hb4,
                8'hcc, 8'hd2, 8'he1, 8'hff: head_term = 1'b1;
                8'h1e: head_idle = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt    = state;
        gap_nxt      = gap_cnt;
        insert       = 1'b0;
        ins_mem      = 1'b0;
        sel          = 2'b00;
        tuser        = 2'b00;
        netq_read    = 1'b0;
        reqq_read    = 1'b0;
        memq_read    = 1'b0;
        underrun_err = 1'b0;
        // outputs are held quiet for the whole time reset is asserted
        if (reset) begin
            case (state)
                ST_GAP: begin
                    if (head_start && (gap_cnt >= GAP_INIT)) begin
                        sel       = 2'b11;
                        netq_read = 1'b1;
                        state_nxt = ST_FRAME;
                    end else begin
                        if (gap_cnt != GAP_MAX)
                            gap_nxt = gap_cnt + 1'b1;
                        if (ipg_en && (!reqq_empty || !memq_empty) &&
                            (netq_empty || head_idle || head_start)) begin
                            insert    = 1'b1;
                            ins_mem   = !memq_empty && (reqq_empty || rr_mem);
                            sel       = ins_mem ? 2'b10 : 2'b01;
                            tuser     = sel;
                            memq_read = ins_mem;
                            reqq_read = !ins_mem;
                            // an idle head is replaced by the message; a START waits
                            netq_read = head_idle;
                        end else if (!netq_empty && !head_start) begin
                            sel       = 2'b11;
                            netq_read = 1'b1;
                        end
                    end
                end
                ST_FRAME: begin
                    if (!netq_empty) begin
                        sel       = 2'b11;
                        netq_read = 1'b1;
                        if (head_term) begin
                            state_nxt = ST_GAP;
                            gap_nxt   = '0;
                        end
                    end else begin
                        underrun_err = 1'b1;
                    end
                end
                default: state_nxt = ST_GAP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_INIT;
            rr_mem  <= 1'b1;
            ins_cnt <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
            if (insert) begin
                rr_mem <= !ins_mem;
                if (ins_cnt != CNT_MAX)
                    ins_cnt <= ins_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ipg_slot_sched.sv
// Directed bench for ipg_slot_sched: FIFO heads and flags are driven cycle by cycle,
// expected mux/strobe vectors are hand-computed.
module tb_ipg_slot_sched;

    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             ipg_en;
    logic             netq_empty;
    logic [1:0]       netq_outc;
    logic [7:0]       netq_bt;
    logic             reqq_empty;
    logic             memq_empty;
    logic             netq_read, reqq_read, memq_read;
    logic [1:0]       sel, tuser;
    logic             underrun_err;
    logic [CNT_W-1:0] ins_cnt;

    int checks = 0;
    int errors = 0;

    // {sel, tuser, netq_read, reqq_read, memq_read, underrun_err}
    localparam logic [7:0] PASS   = 8'b11_00_1_0_0_0;
    localparam logic [7:0] QUIET  = 8'b00_00_0_0_0_0;
    localparam logic [7:0] UND    = 8'b00_00_0_0_0_1;
    localparam logic [7:0] MEM_R  = 8'b10_10_1_0_1_0;
    localparam logic [7:0] MEM_NR = 8'b10_10_0_0_1_0;
    localparam logic [7:0] REQ_R  = 8'b01_01_1_1_0_0;
    localparam logic [1:0] C = 2'b01;
    localparam logic [1:0] D = 2'b10;

    ipg_slot_sched #(
        .MIN_IDLE (3),
        .GAP_W    (4),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ipg_en       (ipg_en),
        .netq_empty   (netq_empty),
        .netq_outc    (netq_outc),
        .netq_bt      (netq_bt),
        .reqq_empty   (reqq_empty),
        .memq_empty   (memq_empty),
        .netq_read    (netq_read),
        .reqq_read    (reqq_read),
        .memq_read    (memq_read),
        .sel          (sel),
        .tuser        (tuser),
        .underrun_err (underrun_err),
        .ins_cnt      (ins_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {sel, tuser, netq_read, reqq_read, memq_read, underrun_err};
    endfunction

    task automatic chk_out(input string tag, input logic [7:0] exp);
        checks++;
        assert (obs() === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs(), exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] exp);
        checks++;
        assert (ins_cnt === exp) else begin
            errors++;
            $error("FAIL %s: observed ins_cnt %0d expected %0d", tag, ins_cnt, exp);
        end
    endtask

    // Called at posedge+1: apply inputs, check before the next edge, advance one cycle.
    task automatic cyc(input string tag, input logic ne, input logic [1:0] hdr,
                       input logic [7:0] bt, input logic re, input logic me,
                       input logic en, input logic [7:0] exp);
        netq_empty = ne;
        netq_outc  = hdr;
        netq_bt    = bt;
        reqq_empty = re;
        memq_empty = me;
        ipg_en     = en;
        #3;
        chk_out(tag, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        ipg_en     = 1'b1;
        netq_empty = 1'b0;
        netq_outc  = C;
        netq_bt    = 8'h78;
        reqq_empty = 1'b1;
        memq_empty = 1'b1;
        #2;
        chk_out("reset_outputs", QUIET);
        chk_cnt("reset_cnt", 3'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // plain frame passthrough, IPG FIFOs empty
        cyc("t1_start", 0, C, 8'h78, 1, 1, 1, PASS);
        cyc("t1_d1",    0, D, 8'h00, 1, 1, 1, PASS);
        cyc("t1_d2",    0, D, 8'h00, 1, 1, 1, PASS);
        cyc("t1_term",  0, C, 8'h87, 1, 1, 1, PASS);
        cyc("t1_idle1", 0, C, 8'h1e, 1, 1, 1, PASS);
        cyc("t1_idle2", 0, C, 8'h1e, 1, 1, 1, PASS);
        chk_cnt("t1_cnt", 3'd0);

        // idle replacement with round-robin, mem first after reset
        cyc("t2_ins1", 0, C, 8'h1e, 0, 0, 1, MEM_R);
        cyc("t2_ins2", 0, C, 8'h1e, 0, 0, 1, REQ_R);
        cyc("t2_ins3", 0, C, 8'h1e, 0, 0, 1, MEM_R);
        cyc("t2_ins4", 0, C, 8'h1e, 0, 1, 1, REQ_R);
        chk_cnt("t2_cnt", 3'd4);

        // TERM then START at once: START held for MIN_IDLE gap cycles filled by mem
        cyc("t3_start",  0, C, 8'h78, 1, 1, 1, PASS);
        cyc("t3_term",   0, C, 8'hb4, 1, 1, 1, PASS);
        cyc("t3_hold1",  0, C, 8'h33, 1, 0, 1, MEM_NR);
        cyc("t3_hold2",  0, C, 8'h33, 1, 0, 1, MEM_NR);
        cyc("t3_hold3",  0, C, 8'h33, 1, 0, 1, MEM_NR);
        cyc("t3_start2", 0, C, 8'h33, 1, 0, 1, PASS);
        cyc("t3_noins",  0, D, 8'h00, 1, 0, 1, PASS);
        chk_cnt("t3_cnt", 3'd7);

        // underrun in frame, then TERM returns to GAP; counter saturates
        cyc("t4_und1",  1, C, 8'h00, 1, 0, 1, UND);
        cyc("t4_und2",  1, C, 8'h00, 1, 0, 1, UND);
        cyc("t4_term",  0, C, 8'hcc, 1, 0, 1, PASS);
        cyc("t4_gapin", 1, C, 8'h00, 1, 0, 1, MEM_NR);
        chk_cnt("t4_cnt_sat", 3'd7);

        // insertion disabled: memq untouched
        cyc("t5_off1",  1, C, 8'h00, 1, 0, 0, QUIET);
        cyc("t5_off2",  1, C, 8'h00, 1, 0, 0, QUIET);
        cyc("t5_idle",  0, C, 8'h1e, 1, 0, 0, PASS);
        chk_cnt("t5_cnt", 3'd7);

        // reset mid-frame aborts it
        cyc("t6_start", 0, C, 8'h66, 1, 0, 0, PASS);
        cyc("t6_data",  0, D, 8'h00, 1, 0, 0, PASS);
        reset      = 1'b0;
        netq_empty = 1'b0;
        netq_outc  = D;
        #2;
        chk_out("t6_in_reset", QUIET);
        chk_cnt("t6_cnt_clr", 3'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc("t6_restart", 0, C, 8'h66, 1, 1, 0, PASS);
        cyc("t6_data2",   0, D, 8'h00, 1, 1, 0, PASS);
        cyc("t6_und",     1, C, 8'h00, 1, 1, 0, UND);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
